// File: rtl/vga_scan_driver.sv
// 640x480@60 scan generator: issues DrawX/DrawY to the colour layers and takes back the merged colour.
// Sync and blank are delayed by PIX_LAT pixel ticks so that they line up with the colour before reaching the DAC pins.
module vga_scan_driver #(
    parameter int H_VIS   = 640,
    parameter int H_FP    = 16,
    parameter int H_SYNC  = 96,
    parameter int H_BP    = 48,
    parameter int V_VIS   = 480,
    parameter int V_FP    = 10,
    parameter int V_SYNC  = 2,
    parameter int V_BP    = 33,
    parameter int PIX_LAT = 1
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [23:0] color_in,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        pix_ce,
    output logic        frame_start,
    output logic        VGA_CLK,
    output logic        VGA_HS,
    output logic        VGA_VS,
    output logic        VGA_BLANK_N,
    output logic [7:0]  VGA_R,
    output logic [7:0]  VGA_G,
    output logic [7:0]  VGA_B
);

    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] HS_FIRST   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_LAST    = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_LAST    = 10'(V_VIS + V_FP + V_SYNC - 1);

    typedef struct packed {
        logic hs_n;
        logic vs_n;
        logic vis;
    } timing_t;

    localparam timing_t TIMING_IDLE = '{hs_n: 1'b1, vs_n: 1'b1, vis: 1'b0};

    logic        phase_q, phase_d;
    logic        pix_ce_q, pix_ce_d;
    logic [9:0]  x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic        fs_q, fs_d;
    timing_t     raw;
    timing_t     tap;
    timing_t     dly_q [PIX_LAT];
    timing_t     dly_d [PIX_LAT];
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        bn_q, bn_d;
    logic [23:0] rgb_q, rgb_d;

    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin : scan_next
        phase_d  = ~phase_q;
        pix_ce_d = phase_q;
        x_d      = x_q;
        y_d      = y_q;
        fs_d     = 1'b0;
        if (pix_ce_q) begin
            if (x_q == H_LAST) begin
                x_d = '0;
                if (y_q == V_LAST) begin
                    y_d  = '0;
                    fs_d = 1'b1;
                end else begin
                    y_d = y_q + 10'd1;
                end
            end else begin
                x_d = x_q + 10'd1;
            end
        end
    end

    always_comb begin : raw_timing
        raw.hs_n = !((x_q >= HS_FIRST) && (x_q <= HS_LAST));
        raw.vs_n = !((y_q >= VS_FIRST) && (y_q <= VS_LAST));
        raw.vis  = (x_q < H_VIS_END) && (y_q < V_VIS_END);
    end

    // Stage 0 takes the timing of the coordinate on DrawX now; the last stage matches color_in.
    always_comb begin : delay_next
        dly_d = dly_q;
        if (pix_ce_q) begin
            dly_d[0] = raw;
            for (int i = 1; i < PIX_LAT; i++) begin
                dly_d[i] = dly_q[i-1];
            end
        end
    end

    assign tap = dly_q[PIX_LAT-1];

    always_comb begin : pins_next
        hs_d  = hs_q;
        vs_d  = vs_q;
        bn_d  = bn_q;
        rgb_d = rgb_q;
        if (pix_ce_q) begin
            hs_d  = tap.hs_n;
            vs_d  = tap.vs_n;
            bn_d  = tap.vis;
            rgb_d = tap.vis ? color_in : 24'h000000;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            phase_q  <= 1'b0;
            pix_ce_q <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            fs_q     <= 1'b0;
            hs_q     <= 1'b1;
            vs_q     <= 1'b1;
            bn_q     <= 1'b0;
            rgb_q    <= '0;
            // NOTE: the delay line is a few flops, not a RAM, so it is reset to keep the pins idle after reset.
            for (int i = 0; i < PIX_LAT; i++) begin
                dly_q[i] <= TIMING_IDLE;
            end
        end else begin
            phase_q  <= phase_d;
            pix_ce_q <= pix_ce_d;
            x_q      <= x_d;
            y_q      <= y_d;
            fs_q     <= fs_d;
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            bn_q     <= bn_d;
            rgb_q    <= rgb_d;
            dly_q    <= dly_d;
        end
    end

    assign DrawX       = x_q;
    assign DrawY       = y_q;
    assign pix_ce      = pix_ce_q;
    assign frame_start = fs_q;
    assign VGA_CLK     = phase_q;
    assign VGA_HS      = hs_q;
    assign VGA_VS      = vs_q;
    assign VGA_BLANK_N = bn_q;
    assign VGA_R       = rgb_q[23:16];
    assign VGA_G       = rgb_q[15:8];
    assign VGA_B       = rgb_q[7:0];

endmodule
